// File: rtl/credit_input_buffer.sv
// Credit-based input buffer: a DEPTH-slot flit FIFO with a packet-forwarding
// FSM that requests a route, forwards header, size and payload flits, and
// returns to IDLE between packets.
module credit_input_buffer #(
    parameter int FLIT_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           rx,
    input  logic [FLIT_WIDTH-1:0]          data_in,
    output logic                           credit_o,
    output logic                           h,
    input  logic                           ack_h,
    output logic                           data_av,
    output logic [FLIT_WIDTH-1:0]          data,
    input  logic                           data_ack,
    output logic                           sender,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy,
    output logic                           overflow_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SEND_HDR,
        SEND_SIZE,
        SEND_PAY
    } state_t;

    state_t                  state;
    logic [FLIT_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]           head;
    logic [AW-1:0]           tail;
    logic [CW-1:0]           count;
    logic [FLIT_WIDTH-1:0]   flit_cnt;
    logic                    push;
    logic                    pop;

    // Flow-control and handshake decode from registered state
    always_comb begin
        credit_o  = (count < FULL_COUNT);
        data_av   = sender && (count != '0);
        push      = rx && credit_o;
        pop       = data_av && data_ack;
        data      = mem[head];
        occupancy = count;
    end

    // Flit storage: write at tail on push
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem <= '{default: '0};
        end else if (push) begin
            mem[tail] <= data_in;
        end
    end

    // Head/tail pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
        end
    end

    // Occupancy counter: simultaneous push and pop cancel out
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag: set whenever a strobed flit finds no credit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_err <= 1'b0;
        end else if (rx && !credit_o) begin
            overflow_err <= 1'b1;
        end
    end

    // Packet FSM; h and sender are registered alongside the state so they
    // always reflect the state being entered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            flit_cnt <= '0;
            h        <= 1'b0;
            sender   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= REQ;
                        h     <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack_h) begin
                        state  <= SEND_HDR;
                        h      <= 1'b0;
                        sender <= 1'b1;
                    end
                end
                SEND_HDR: begin
                    if (pop) begin
                        state <= SEND_SIZE;
                    end
                end
                SEND_SIZE: begin
                    if (pop) begin
                        if (data == '0) begin
                            state  <= IDLE;
                            sender <= 1'b0;
                        end else begin
                            flit_cnt <= data;
                            state    <= SEND_PAY;
                        end
                    end
                end
                SEND_PAY: begin
                    if (pop) begin
                        flit_cnt <= flit_cnt - FLIT_WIDTH'(1);
                        if (flit_cnt == FLIT_WIDTH'(1)) begin
                            state  <= IDLE;
                            sender <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    flit_cnt <= '0;
                    h        <= 1'b0;
                    sender   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_credit_input_buffer.sv
// Self-checking bench for credit_input_buffer: a queue-based packet model,
// a per-cycle comparator, directed scenarios and a randomized phase.
module tb_credit_input_buffer;

    localparam int FW    = 16;
    localparam int DEPTH = 4;

    logic            clock;
    logic            reset;
    logic            rx;
    logic [FW-1:0]   data_in;
    logic            credit_o;
    logic            h;
    logic            ack_h;
    logic            data_av;
    logic [FW-1:0]   data;
    logic            data_ack;
    logic            sender;
    logic [2:0]      occupancy;
    logic            overflow_err;

    credit_input_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .rx(rx), .data_in(data_in),
        .credit_o(credit_o), .h(h), .ack_h(ack_h), .data_av(data_av),
        .data(data), .data_ack(data_ack), .sender(sender),
        .occupancy(occupancy), .overflow_err(overflow_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buffer is a queue; packet progress is "phase" (0 idle, 1 requesting,
    // 2 forwarding) plus the number of flits already forwarded in the packet.
    logic [FW-1:0] m_q[$];
    logic [FW-1:0] m_log[$];
    bit            m_ovf   = 0;
    int            m_phase = 0;
    int            m_k     = 0;
    int            m_size  = 0;
    int            m_occ;
    bit            m_push, m_pop, m_done;
    logic [FW-1:0] m_f;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_ovf   = 0;
            m_phase = 0;
            m_k     = 0;
            m_size  = 0;
        end else begin
            m_occ  = m_q.size();
            m_push = rx && (m_occ < DEPTH);
            m_pop  = (m_phase == 2) && (m_occ > 0) && data_ack;
            if (rx && !(m_occ < DEPTH)) m_ovf = 1;
            case (m_phase)
                0: if (m_occ > 0) m_phase = 1;
                1: if (ack_h) begin m_phase = 2; m_k = 0; end
                default: begin
                    if (m_pop) begin
                        m_f = m_q[0];
                        m_log.push_back(m_f);
                        if (m_k == 1) m_size = int'(m_f);
                        m_done = (m_k == 1 && m_f == 0) || (m_k >= 2 && (m_k - 1) == m_size);
                        m_k++;
                        if (m_done) m_phase = 0;
                    end
                end
            endcase
            if (m_pop) void'(m_q.pop_front());
            if (m_push) m_q.push_back(data_in);
        end
    end

    // ---------------- per-cycle comparator ----------------
    bit chk_on = 0;
    bit prev_h = 0, prev_s = 0;
    int h_rises = 0, s_rises = 0;

    always @(negedge clock) begin
        if (chk_on) begin
            chk("credit_o", credit_o, m_q.size() < DEPTH);
            chk("occupancy", occupancy, m_q.size());
            chk("h", h, m_phase == 1);
            chk("sender", sender, m_phase == 2);
            chk("data_av", data_av, (m_phase == 2) && (m_q.size() > 0));
            chk("overflow_err", overflow_err, m_ovf);
            if (m_q.size() > 0) chk("data", data, m_q[0]);
            if (!reset) chk("data_rst", data, 0);
        end
        if (h && !prev_h) h_rises++;
        if (sender && !prev_s) s_rises++;
        prev_h = h;
        prev_s = sender;
    end

    // ---------------- stimulus helpers ----------------
    logic [FW-1:0] tx[$];
    logic [FW-1:0] exp_q[$];
    int  ack_mode  = 0;   // 0 low, 1 follow h, 2 random
    int  dack_mode = 0;   // 0 low, 1 high, 2 random
    bit  force_rx  = 0;
    bit  gap_rand  = 0;

    task automatic cycle();
        @(posedge clock);
        #1;
        case (ack_mode)
            0:       ack_h = 1'b0;
            1:       ack_h = h;
            default: ack_h = 1'($urandom_range(0, 1));
        endcase
        case (dack_mode)
            0:       data_ack = 1'b0;
            1:       data_ack = 1'b1;
            default: data_ack = 1'($urandom_range(0, 1));
        endcase
        if (tx.size() > 0 && (force_rx || credit_o) && (!gap_rand || $urandom_range(0, 3) != 0)) begin
            rx      = 1'b1;
            data_in = tx.pop_front();
        end else begin
            rx      = 1'b0;
            data_in = FW'($urandom);
        end
    endtask

    function automatic bit drained();
        return tx.size() == 0 && m_q.size() == 0 && m_phase == 0;
    endfunction

    task automatic run_drain(input string name, input int budget);
        int n = 0;
        while (!drained() && n < budget) begin
            cycle();
            n++;
        end
        chk({name, "_timeout"}, drained(), 1);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        rx    = 1'b0;
        tx.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        m_log.delete();
    endtask

    task automatic chk_log(input string name);
        int errs = 0;
        chk({name, "_len"}, m_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < m_log.size(); i++)
            if (m_log[i] !== exp_q[i]) errs++;
        chk({name, "_order"}, errs, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        reset = 1'b0; rx = 1'b0; data_in = '0; ack_h = 1'b0; data_ack = 1'b0;
        chk_on = 1;

        // Reset held with rx toggling
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            rx = ~rx; data_in = FW'($urandom); ack_h = rx; data_ack = 1'b1;
        end
        @(negedge clock);
        chk("rst_h", h, 0);
        chk("rst_sender", sender, 0);
        chk("rst_data_av", data_av, 0);
        chk("rst_data", data, 0);
        chk("rst_credit", credit_o, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_ovf", overflow_err, 0);
        @(posedge clock); #1;
        rx = 1'b0; ack_h = 1'b0; data_ack = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("rel_credit", credit_o, 1);
        chk("rel_occ", occupancy, 0);

        // Basic packet with two payload flits
        ack_mode = 1; dack_mode = 1;
        tx = '{16'h0011, 16'h0002, 16'hAAAA, 16'hBBBB};
        exp_q = '{16'h0011, 16'h0002, 16'hAAAA, 16'hBBBB};
        run_drain("basic", 50);
        chk_log("basic_log");
        chk("basic_occ", occupancy, 0);
        chk("basic_sender", sender, 0);

        // Fill to capacity without grants, then overflow
        do_reset();
        ack_mode = 0; dack_mode = 0;
        tx = '{16'h0055, 16'h0002, 16'h0101, 16'h0202};
        repeat (6) cycle();
        chk("full_occ", occupancy, 4);
        chk("full_credit", credit_o, 0);
        chk("full_h", h, 1);
        chk("full_data", data, 16'h0055);
        force_rx = 1;
        tx.push_back(16'h1234);
        repeat (2) cycle();
        force_rx = 0;
        chk("ovf_flag", overflow_err, 1);
        chk("ovf_occ", occupancy, 4);
        ack_mode = 1; dack_mode = 1;
        exp_q = '{16'h0055, 16'h0002, 16'h0101, 16'h0202};
        run_drain("ovf_drain", 50);
        chk_log("ovf_log");
        begin
            int n1234 = 0;
            foreach (m_log[i]) if (m_log[i] == 16'h1234) n1234++;
            chk("ovf_dropped", n1234, 0);
        end
        chk("ovf_sticky", overflow_err, 1);

        // Zero-size packets back to back
        do_reset();
        h_rises = 0;
        tx = '{16'h0022, 16'h0000, 16'h0033, 16'h0000};
        exp_q = '{16'h0022, 16'h0000, 16'h0033, 16'h0000};
        run_drain("zero", 60);
        chk_log("zero_log");
        chk("zero_h_rises", h_rises, 2);

        // Ten back-to-back size-3 packets
        do_reset();
        exp_q.delete();
        for (int p = 0; p < 10; p++) begin
            logic [FW-1:0] w;
            w = FW'(16'h0100 + p); tx.push_back(w); exp_q.push_back(w);
            tx.push_back(16'h0003); exp_q.push_back(16'h0003);
            for (int j = 0; j < 3; j++) begin
                w = FW'($urandom); tx.push_back(w); exp_q.push_back(w);
            end
        end
        s_rises = 0;
        run_drain("b2b", 500);
        chk_log("b2b_log");
        chk("b2b_sender_rises", s_rises, 10);
        chk("b2b_ovf", overflow_err, 0);

        // Reset in the middle of a payload
        do_reset();
        tx = '{16'h0066, 16'h0005, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        begin
            int n = 0;
            while (!(m_phase == 2 && m_k >= 4) && n < 60) begin
                cycle();
                n++;
            end
            chk("midrst_reached", m_phase == 2 && m_k >= 4, 1);
        end
        reset = 1'b0;
        #1;
        chk("midrst_occ", occupancy, 0);
        chk("midrst_sender", sender, 0);
        chk("midrst_data_av", data_av, 0);
        chk("midrst_data", data, 0);
        chk("midrst_credit", credit_o, 1);
        tx.delete();
        rx = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        m_log.delete();
        tx = '{16'h0044, 16'h0001, 16'hCCCC};
        exp_q = '{16'h0044, 16'h0001, 16'hCCCC};
        run_drain("post_rst", 50);
        chk_log("post_rst_log");

        // Randomized traffic with well-formed packets and random handshakes
        do_reset();
        exp_q.delete();
        for (int b = 0; b < 60; b++) begin
            int sz;
            logic [FW-1:0] w;
            sz = $urandom_range(0, 4);
            w = FW'($urandom); tx.push_back(w); exp_q.push_back(w);
            tx.push_back(FW'(sz)); exp_q.push_back(FW'(sz));
            for (int j = 0; j < sz; j++) begin
                w = FW'($urandom); tx.push_back(w); exp_q.push_back(w);
            end
            ack_mode  = $urandom_range(1, 2);
            dack_mode = $urandom_range(1, 2);
            gap_rand  = 1'($urandom_range(0, 1));
            repeat (12) cycle();
        end
        ack_mode = 1; dack_mode = 1; gap_rand = 0;
        run_drain("rand", 3000);
        chk_log("rand_log");
        chk("rand_ovf", overflow_err, 0);

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
